// File: rtl/seq_shift_unit.sv
// Iterative shifter: loads an operand, then applies one bit of sll/srl/sra/rotr per
// clock until the loaded count is exhausted, then pulses done for one cycle.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic [1:0]         dbg_state_o
);

  // Handshake: start is a request that is accepted only on an edge where the unit
  // is IDLE; done is a single-cycle strobe marking data_out as final, and data_out
  // then stays valid until the next accepted start.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0]         OP_SLL   = 2'b00;
  localparam logic [1:0]         OP_SRL   = 2'b01;
  localparam logic [1:0]         OP_SRA   = 2'b10;
  localparam logic [1:0]         OP_ROTR  = 2'b11;
  localparam logic [SHAMT_W-1:0] WIDTH_N  = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] ROT_MASK = SHAMT_W'(WIDTH - 1);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  state_e             state_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [1:0]         op_q;
  logic               busy_q;
  logic               done_q;

  logic [SHAMT_W-1:0] load_cnt_d;
  logic [WIDTH-1:0]   step_d;

  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0]       f_op,
                                                 input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (f_op)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {v[0], v[WIDTH-1:1]};
    endcase
    shift_one = r;
  endfunction

  // Linear shifts saturate at WIDTH steps (the result is fully flushed by then);
  // rotation is periodic, so only the amount modulo WIDTH matters.
  always_comb begin
    load_cnt_d = '0;
    if (op == OP_ROTR) begin
      load_cnt_d = shamt & ROT_MASK;
    end else if (shamt > WIDTH_N) begin
      load_cnt_d = WIDTH_N;
    end else begin
      load_cnt_d = shamt;
    end
  end

  always_comb begin
    step_d = shift_one(op_q, data_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            data_q <= data_in;
            op_q   <= op;
            cnt_q  <= load_cnt_d;
            if (load_cnt_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          data_q <= step_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign data_out    = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: table of shift vectors with hand-computed
// results and latencies, plus reset-abort and back-to-back sequences.
module tb_seq_shift_unit;

  localparam int W  = 32;
  localparam int SW = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  data_in;
  logic [SW-1:0] shamt;
  logic          busy;
  logic          done;
  logic [W-1:0]  data_out;
  logic [1:0]    dbg_state;

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  din;
    logic [SW-1:0] shamt;
    logic [W-1:0]  exp;
    int            n;
  } vec_t;

  vec_t vecs[13];

  seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .data_in(data_in),
    .shamt(shamt),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Drive one operation and follow it to its done pulse, checking latency,
  // busy duration, the result and that the result holds afterwards.
  task automatic run_op(input string name, input logic [1:0] v_op, input logic [W-1:0] v_din,
                        input logic [SW-1:0] v_shamt, input logic [W-1:0] v_exp, input int v_n);
    int k;
    int busy_cnt;
    bit seen;
    logic [W-1:0] exp_v;
    @(negedge clk);
    op      = v_op;
    data_in = v_din;
    shamt   = v_shamt;
    start   = 1'b1;
    exp_q.push_back(v_exp);
    @(posedge clk);
    k = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (k == 0) begin
        start   = 1'b0;
        op      = 2'($urandom_range(0, 3));
        data_in = $urandom;
        shamt   = SW'($urandom_range(0, 63));
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        k++;
      end
    end
    exp_v = exp_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 100 cycles, required %0d", name, v_n);
    end else begin
      check({name, " latency"}, W'(k), W'(v_n));
      check({name, " busy_cycles"}, W'(busy_cnt), W'(v_n));
      check({name, " data"}, data_out, exp_v);
      @(negedge clk);
      check({name, " done_pulse"}, W'(done), W'(0));
      check({name, " hold"}, data_out, exp_v);
    end
  endtask

  initial begin
    int hits_done;
    int hits_busy;
    int k;
    bit seen;
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    data_in = '0;
    shamt   = '0;

    vecs[0]  = '{2'b00, 32'h0000ABCD, 6'd16, 32'hABCD0000, 16};
    vecs[1]  = '{2'b10, 32'h80000010, 6'd4,  32'hF8000001, 4};
    vecs[2]  = '{2'b10, 32'h80000010, 6'd40, 32'hFFFFFFFF, 32};
    vecs[3]  = '{2'b01, 32'hFFFFFFFF, 6'd0,  32'hFFFFFFFF, 0};
    vecs[4]  = '{2'b11, 32'h00000001, 6'd33, 32'h80000000, 1};
    vecs[5]  = '{2'b00, 32'h00000001, 6'd3,  32'h00000008, 3};
    vecs[6]  = '{2'b01, 32'h80000000, 6'd31, 32'h00000001, 31};
    vecs[7]  = '{2'b00, 32'hFFFFFFFF, 6'd63, 32'h00000000, 32};
    vecs[8]  = '{2'b11, 32'h12345678, 6'd8,  32'h78123456, 8};
    vecs[9]  = '{2'b10, 32'h7FFFFFFF, 6'd32, 32'h00000000, 32};
    vecs[10] = '{2'b01, 32'hF0F0F0F0, 6'd4,  32'h0F0F0F0F, 4};
    vecs[11] = '{2'b11, 32'h80000001, 6'd32, 32'h80000001, 0};
    vecs[12] = '{2'b11, 32'h0000000F, 6'd63, 32'h0000001E, 31};

    // reset state, then idle with no start
    repeat (2) @(negedge clk);
    check("rst data", data_out, 32'h0);
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    reset = 1'b1;
    hits_done = 0;
    hits_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) hits_done++;
      if (busy) hits_busy++;
    end
    check("idle data", data_out, 32'h0);
    check("idle done_count", W'(hits_done), W'(0));
    check("idle busy_count", W'(hits_busy), W'(0));
    check("idle state", W'(dbg_state), W'(0));

    // table-driven operations
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].shamt,
             vecs[i].exp, vecs[i].n);
    end

    // reset mid-shift after 5 shifts of sll by 20
    @(negedge clk);
    op = 2'b00; data_in = 32'h1; shamt = 6'd20; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort pre data", data_out, 32'h00000020);
    check("abort pre busy", W'(busy), W'(1));
    reset = 1'b0;
    #1;
    check("abort data", data_out, 32'h0);
    check("abort busy", W'(busy), W'(0));
    check("abort done", W'(done), W'(0));
    check("abort state", W'(dbg_state), W'(0));
    @(negedge clk);
    reset = 1'b1;
    hits_done = 0;
    hits_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) hits_done++;
      if (busy) hits_busy++;
    end
    check("post_abort done_count", W'(hits_done), W'(0));
    check("post_abort busy_count", W'(hits_busy), W'(0));
    check("post_abort data", data_out, 32'h0);

    // back-to-back with start held high; data_in changes mid-shift
    @(negedge clk);
    op = 2'b00; data_in = 32'h1; shamt = 6'd3; start = 1'b1;
    exp_q.push_back(32'h00000008);
    exp_q.push_back(32'h000007F8);
    @(posedge clk);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (k == 1) data_in = 32'hFF;
      if (done) seen = 1'b1;
      else k++;
    end
    check("b2b first seen", W'(seen), W'(1));
    check("b2b first latency", W'(k), W'(3));
    check("b2b first data", data_out, exp_q.pop_front());
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (k == 0) check("b2b gap busy", W'(busy), W'(0));
      if (done) seen = 1'b1;
      else k++;
    end
    start = 1'b0;
    check("b2b second seen", W'(seen), W'(1));
    check("b2b second spacing", W'(k + 1), W'(5));
    check("b2b second data", data_out, exp_q.pop_front());
    repeat (3) @(negedge clk);
    check("b2b final idle", W'(dbg_state), W'(0));
    check("b2b final hold", data_out, 32'h000007F8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
